// File: rtl/wb_check_pkg.sv
// Shared types and the entry comparison rule for the commit-trace scoreboard.
// The trace entry layout is fixed at 32-bit PC/data to match the RV32I core.
package wb_check_pkg;

  localparam int TRACE_XLEN = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] val;
    logic [TRACE_XLEN-1:0] mask;
    logic                  nz;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } chk_state_t;

  // nz entries accept any non-zero value; otherwise only masked bits are compared
  function automatic logic entry_match(
    input trace_entry_t          e,
    input logic [TRACE_XLEN-1:0] pc,
    input logic [4:0]            rd,
    input logic [TRACE_XLEN-1:0] data
  );
    logic data_ok;
    if (e.nz) begin
      data_ok = (data != {TRACE_XLEN{1'b0}});
    end else begin
      data_ok = (((data ^ e.val) & e.mask) == {TRACE_XLEN{1'b0}});
    end
    return (pc == e.pc) && (rd == e.rd) && data_ok;
  endfunction

endpackage

// File: rtl/wb_trace_table.sv
// Expected-trace storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded table survives a reset.
module wb_trace_table
  import wb_check_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  trace_entry_t     wentry,
  input  logic [IDX_W-1:0] ridx,
  output trace_entry_t     rentry
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

  trace_entry_t mem_r [DEPTH];

  // Entry write; indices past the table end are dropped
  always_ff @(posedge clk) begin
    if (we && (widx < DEPTH_I)) begin
      mem_r[widx[AW-1:0]] <= wentry;
    end
  end

  // Combinational lookup, all-zero entry for out-of-range indices
  always_comb begin
    if (ridx < DEPTH_I) begin
      rentry = mem_r[ridx[AW-1:0]];
    end else begin
      rentry = {$bits(trace_entry_t){1'b0}};
    end
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Commit-trace scoreboard: checks each register writeback of the core against
// a programmed expected-trace table, in order, and keeps pass/error/extra counts.
module wb_trace_checker
  import wb_check_pkg::*;
#(
  parameter int XLEN        = TRACE_XLEN,
  parameter int DEPTH       = 32,
  parameter int IDX_W       = $clog2(DEPTH + 1),
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [XLEN-1:0]  cfg_pc,
  input  logic [4:0]       cfg_rd,
  input  logic [XLEN-1:0]  cfg_val,
  input  logic [XLEN-1:0]  cfg_mask,
  input  logic             cfg_nz,
  input  logic [IDX_W-1:0] cfg_count,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] unexp_count,
  output logic             err_valid,
  output logic [IDX_W-1:0] err_idx,
  output logic [XLEN-1:0]  err_got
);

  localparam logic [IDX_W-1:0] DEPTH_I  = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + CNT_ONE;
    end
  endfunction

  chk_state_t       state_r, state_nx;
  logic [IDX_W-1:0] idx_r, idx_nx, count_r, count_nx;
  logic [CNT_W-1:0] pass_r, pass_nx, err_r, err_nx, unexp_r, unexp_nx;
  logic             busy_r, done_r, fail_r;
  logic             errv_r, errv_nx;
  logic [IDX_W-1:0] eidx_r, eidx_nx;
  logic [XLEN-1:0]  egot_r, egot_nx;

  trace_entry_t     cfg_entry_s, cur_entry_s;
  logic             tbl_we_s, wb_take_s, hit_s;
  logic [IDX_W-1:0] count_clamp_s;

  assign cfg_entry_s   = '{pc: cfg_pc, rd: cfg_rd, val: cfg_val, mask: cfg_mask, nz: cfg_nz};
  assign tbl_we_s      = reset && cfg_we && (state_r == IDLE);
  assign wb_take_s     = wb_valid && (wb_rd != 5'd0);
  assign hit_s         = entry_match(cur_entry_s, wb_pc, wb_rd, wb_data);
  assign count_clamp_s = (cfg_count > DEPTH_I) ? DEPTH_I : cfg_count;

  wb_trace_table #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we_s),
    .widx  (cfg_idx),
    .wentry(cfg_entry_s),
    .ridx  (idx_r),
    .rentry(cur_entry_s)
  );

  // Next-state and result computation; start overrides any coincident writeback
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    count_nx = count_r;
    pass_nx  = pass_r;
    err_nx   = err_r;
    unexp_nx = unexp_r;
    errv_nx  = 1'b0;
    eidx_nx  = eidx_r;
    egot_nx  = egot_r;
    if (start) begin
      idx_nx   = IDX_ZERO;
      count_nx = count_clamp_s;
      pass_nx  = CNT_ZERO;
      err_nx   = CNT_ZERO;
      unexp_nx = CNT_ZERO;
      state_nx = (count_clamp_s == IDX_ZERO) ? DONE : RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (wb_take_s) begin
            idx_nx = idx_r + IDX_ONE;
            if (hit_s) begin
              pass_nx = sat_inc(pass_r);
            end else begin
              err_nx  = sat_inc(err_r);
              errv_nx = 1'b1;
              eidx_nx = idx_r;
              egot_nx = wb_data;
            end
            if (idx_nx == count_r) begin
              state_nx = DONE;
            end else if (!hit_s && STOP_ON_ERR) begin
              state_nx = HALT;
            end else begin
              state_nx = RUN;
            end
          end else begin
            state_nx = RUN;
          end
        end
        DONE: begin
          if (wb_take_s) begin
            unexp_nx = sat_inc(unexp_r);
          end else begin
            unexp_nx = unexp_r;
          end
        end
        IDLE:    state_nx = IDLE;
        HALT:    state_nx = HALT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      count_r <= IDX_ZERO;
      pass_r  <= CNT_ZERO;
      err_r   <= CNT_ZERO;
      unexp_r <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
      errv_r  <= 1'b0;
      eidx_r  <= IDX_ZERO;
      egot_r  <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      count_r <= count_nx;
      pass_r  <= pass_nx;
      err_r   <= err_nx;
      unexp_r <= unexp_nx;
      busy_r  <= (state_nx == RUN);
      done_r  <= (state_nx == DONE);
      fail_r  <= (err_nx != CNT_ZERO) || (unexp_nx != CNT_ZERO);
      errv_r  <= errv_nx;
      eidx_r  <= eidx_nx;
      egot_r  <= egot_nx;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign fail        = fail_r;
  assign pass_count  = pass_r;
  assign err_count   = err_r;
  assign unexp_count = unexp_r;
  assign err_valid   = errv_r;
  assign err_idx     = eidx_r;
  assign err_got     = egot_r;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed scenarios plus randomized traces, with a
// free-running and a halt-on-error instance both scored against a reference model.
module tb_wb_trace_checker;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, cfg_we, cfg_nz, wb_valid;
  logic [IDX_W-1:0] cfg_idx, cfg_count;
  logic [XLEN-1:0]  cfg_pc, cfg_val, cfg_mask, wb_pc, wb_data;
  logic [4:0]       cfg_rd, wb_rd;

  logic             busy [2], done [2], fail [2], err_valid [2];
  logic [CNT_W-1:0] pass_count [2], err_count [2], unexp_count [2];
  logic [IDX_W-1:0] err_idx [2];
  logic [XLEN-1:0]  err_got [2];

  wb_trace_checker #(.STOP_ON_ERR(1'b0)) u_free (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pc(cfg_pc), .cfg_rd(cfg_rd), .cfg_val(cfg_val), .cfg_mask(cfg_mask),
    .cfg_nz(cfg_nz), .cfg_count(cfg_count), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .pass_count(pass_count[0]), .err_count(err_count[0]), .unexp_count(unexp_count[0]),
    .err_valid(err_valid[0]), .err_idx(err_idx[0]), .err_got(err_got[0])
  );

  wb_trace_checker #(.STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pc(cfg_pc), .cfg_rd(cfg_rd), .cfg_val(cfg_val), .cfg_mask(cfg_mask),
    .cfg_nz(cfg_nz), .cfg_count(cfg_count), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .pass_count(pass_count[1]), .err_count(err_count[1]), .unexp_count(unexp_count[1]),
    .err_valid(err_valid[1]), .err_idx(err_idx[1]), .err_got(err_got[1])
  );

  int total = 0;
  int bad   = 0;

  // reference table and per-instance model; mode 0 idle, 1 run, 2 done, 3 halt
  logic [31:0] t_pc [DEPTH], t_val [DEPTH], t_mask [DEPTH];
  logic [4:0]  t_rd [DEPTH];
  logic        t_nz [DEPTH];
  int          m_mode [2], m_idx [2], m_cnt [2], m_pass [2], m_err [2], m_unexp [2], m_eidx [2];
  logic [31:0] m_egot [2];
  bit          m_errv [2];

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0h exp=%0h", tag, i, got, exp);
    end
  endtask

  function automatic bit ref_match(input int k);
    bit data_ok;
    if (t_nz[k]) data_ok = (wb_data != 32'd0);
    else         data_ok = (((wb_data ^ t_val[k]) & t_mask[k]) == 32'd0);
    return (wb_pc == t_pc[k]) && (wb_rd == t_rd[k]) && data_ok;
  endfunction

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_step();
    int ci;
    bit ok;
    ci = int'(cfg_idx);
    if (reset && cfg_we && m_mode[0] == 0 && ci < DEPTH) begin
      t_pc[ci] = cfg_pc; t_rd[ci] = cfg_rd; t_val[ci] = cfg_val;
      t_mask[ci] = cfg_mask; t_nz[ci] = cfg_nz;
    end
    for (int i = 0; i < 2; i++) begin
      m_errv[i] = 1'b0;
      if (!reset) begin
        m_mode[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_pass[i] = 0;
        m_err[i] = 0; m_unexp[i] = 0; m_eidx[i] = 0; m_egot[i] = 32'd0;
      end else if (start) begin
        m_pass[i] = 0; m_err[i] = 0; m_unexp[i] = 0; m_idx[i] = 0;
        m_cnt[i]  = (int'(cfg_count) > DEPTH) ? DEPTH : int'(cfg_count);
        m_mode[i] = (m_cnt[i] == 0) ? 2 : 1;
      end else if (wb_valid && wb_rd != 5'd0) begin
        if (m_mode[i] == 1) begin
          ok = ref_match(m_idx[i]);
          if (ok) m_pass[i] = sat(m_pass[i]);
          else begin
            m_err[i] = sat(m_err[i]); m_errv[i] = 1'b1;
            m_eidx[i] = m_idx[i]; m_egot[i] = wb_data;
          end
          m_idx[i]++;
          if (m_idx[i] == m_cnt[i]) m_mode[i] = 2;
          else if (!ok && i == 1) m_mode[i] = 3;
        end else if (m_mode[i] == 2) begin
          m_unexp[i] = sat(m_unexp[i]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 32'(busy[i]), 32'(m_mode[i] == 1));
      chk("done", i, 32'(done[i]), 32'(m_mode[i] == 2));
      chk("fail", i, 32'(fail[i]), 32'(m_err[i] != 0 || m_unexp[i] != 0));
      chk("pass_count", i, 32'(pass_count[i]), 32'(m_pass[i]));
      chk("err_count", i, 32'(err_count[i]), 32'(m_err[i]));
      chk("unexp_count", i, 32'(unexp_count[i]), 32'(m_unexp[i]));
      chk("err_valid", i, 32'(err_valid[i]), 32'(m_errv[i]));
      if (m_errv[i]) begin
        chk("err_idx", i, 32'(err_idx[i]), 32'(m_eidx[i]));
        chk("err_got", i, err_got[i], m_egot[i]);
      end
    end
  endtask

  // called at a negedge with inputs set; returns at the next negedge with strobes cleared
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] val, input logic [31:0] mask, input logic nz);
    cfg_idx = IDX_W'(idx); cfg_pc = pc; cfg_rd = rd; cfg_val = val;
    cfg_mask = mask; cfg_nz = nz; cfg_we = 1'b1;
    step();
  endtask

  task automatic go(input int count);
    cfg_count = IDX_W'(count); start = 1'b1; step();
  endtask

  task automatic wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    wb_pc = pc; wb_rd = rd; wb_data = data; wb_valid = 1'b1; step();
  endtask

  task automatic load_base();
    load(0, 32'h1000, 5'd1, 32'hFEDCC000, 32'hFFFFFFFF, 1'b0);
    load(1, 32'h1004, 5'd1, 32'hFEDCBA98, 32'hFFFFFFFF, 1'b0);
    load(2, 32'h1008, 5'd2, 32'h0FEDCBA9, 32'hFFFFFFFF, 1'b0);
  endtask

  initial begin
    int k, act, n;
    logic [31:0] d;
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; wb_valid = 1'b0; cfg_nz = 1'b0;
    cfg_idx = '0; cfg_count = '0; cfg_pc = '0; cfg_val = '0; cfg_mask = '0; cfg_rd = '0;
    wb_pc = '0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < 2; i++) m_mode[i] = 0;
    @(negedge clk);
    step();
    do_reset();

    // full match, back-to-back writebacks
    load_base();
    go(3);
    wb(32'h1000, 5'd1, 32'hFEDCC000);
    wb(32'h1004, 5'd1, 32'hFEDCBA98);
    wb(32'h1008, 5'd2, 32'h0FEDCBA9);
    chk("t1_pass", 0, 32'(pass_count[0]), 32'd3);
    chk("t1_done", 0, 32'(done[0]), 32'd1);
    chk("t1_fail", 0, 32'(fail[0]), 32'd0);

    // single data mismatch at entry 1
    do_reset();
    go(3);
    wb(32'h1000, 5'd1, 32'hFEDCC000);
    wb(32'h1004, 5'd1, 32'hFEDCBA99);
    chk("t2_ev", 0, 32'(err_valid[0]), 32'd1);
    chk("t2_idx", 0, 32'(err_idx[0]), 32'd1);
    chk("t2_got", 0, err_got[0], 32'hFEDCBA99);
    wb(32'h1008, 5'd2, 32'h0FEDCBA9);
    chk("t2_err", 0, 32'(err_count[0]), 32'd1);
    chk("t2_pass", 0, 32'(pass_count[0]), 32'd2);
    chk("t2_fail", 0, 32'(fail[0]), 32'd1);

    // non-zero mode and partial mask
    do_reset();
    load(0, 32'h1078, 5'd19, 32'h0, 32'h0, 1'b1);
    load(1, 32'h1078, 5'd19, 32'h0, 32'h0, 1'b1);
    load(2, 32'h1080, 5'd5, 32'h0000C0C0, 32'h0000FFFF, 1'b0);
    go(3);
    wb(32'h1078, 5'd19, 32'h0);
    wb(32'h1078, 5'd19, 32'h00001F40);
    wb(32'h1080, 5'd5, 32'hFFFFC0C0);
    chk("t3_pass", 0, 32'(pass_count[0]), 32'd2);
    chk("t3_err", 0, 32'(err_count[0]), 32'd1);

    // halt on first error, wb ignored while halted, start restarts
    do_reset();
    go(2);
    wb(32'h1000, 5'd1, 32'h0);
    chk("t4_busy", 1, 32'(busy[1]), 32'd0);
    wb(32'h1078, 5'd19, 32'h5);
    chk("t4_err", 1, 32'(err_count[1]), 32'd1);
    go(2);
    chk("t4_rbusy", 1, 32'(busy[1]), 32'd1);
    chk("t4_rerr", 1, 32'(err_count[1]), 32'd0);

    // unexpected writebacks after done, x0 ignored, zero-count start
    do_reset();
    load_base();
    go(2);
    wb(32'h1000, 5'd1, 32'hFEDCC000);
    wb(32'h1004, 5'd1, 32'hFEDCBA98);
    wb(32'h2000, 5'd3, 32'h5);
    wb(32'h2004, 5'd4, 32'h6);
    wb(32'h2008, 5'd0, 32'h7);
    chk("t5_unexp", 0, 32'(unexp_count[0]), 32'd2);
    go(0);
    chk("t5_zdone", 0, 32'(done[0]), 32'd1);
    chk("t5_zfail", 0, 32'(fail[0]), 32'd0);

    // reset mid-run keeps the table; cfg writes outside IDLE are dropped
    do_reset();
    go(2);
    wb(32'h1000, 5'd1, 32'hFEDCC000);
    load(1, 32'hDEAD, 5'd7, 32'h1, 32'hFFFFFFFF, 1'b0);
    do_reset();
    chk("t6_pass", 0, 32'(pass_count[0]), 32'd0);
    go(2);
    wb(32'h1000, 5'd1, 32'hFEDCC000);
    wb(32'h1004, 5'd1, 32'hFEDCBA98);
    chk("t6_rpass", 0, 32'(pass_count[0]), 32'd2);

    // randomized traces against the model
    do_reset();
    for (int e = 0; e < DEPTH; e++)
      load(e, 32'h1000 + 32'(4 * e), 5'($urandom_range(1, 31)), $urandom,
           ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom, ($urandom_range(0, 3) == 0));
    for (int r = 0; r < 20; r++) begin
      do_reset();
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++)
        load(($urandom_range(0, 7) == 0) ? $urandom_range(32, 40) : $urandom_range(0, 9),
             32'h1000 + 32'(4 * $urandom_range(0, 9)), 5'($urandom_range(1, 31)), $urandom,
             ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom, ($urandom_range(0, 3) == 0));
      go(($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 10));
      for (int s = 0; s < 30; s++) begin
        act = $urandom_range(0, 99);
        k = (m_idx[0] < DEPTH) ? m_idx[0] : 0;
        d = t_nz[k] ? ($urandom | 32'd1) : ((t_val[k] & t_mask[k]) | ($urandom & ~t_mask[k]));
        wb_pc = t_pc[k]; wb_rd = t_rd[k]; wb_data = d;
        if (act < 60) begin
          wb_valid = 1'b1;
        end else if (act < 75) begin
          wb_valid = 1'b1;
          if (act < 68) wb_data = d ^ (32'd1 << $urandom_range(0, 31));
          else          wb_pc = wb_pc + 32'd4;
        end else if (act < 82) begin
          wb_valid = 1'b1; wb_rd = 5'd0;
        end else if (act < 85) begin
          wb_valid = 1'b1; start = 1'b1; cfg_count = IDX_W'($urandom_range(0, 12));
        end else if (act < 88) begin
          cfg_we = 1'b1; cfg_idx = IDX_W'($urandom_range(0, 9)); cfg_pc = $urandom;
        end else begin
          wb_valid = 1'b0;
        end
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
